fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Instruction fetch front end for the pipelined RV32I core. It sits between instruction-memory port A (synchronous BRAM, 1-cycle read latency) and the IF/ID decode register. It generates sequential fetch addresses and buffers returned instructions with their PCs in a small FIFO. It presents them to decode with a valid/ready handshake, and flushes on branch/jump redirects from EX.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
redirect  in  1  EX taken branch/jump; flush and refetch
redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0)
imem_en  out  1  read request to instruction memory this cycle
imem_addr  out  32  byte address of read; always word aligned
imem_rdata  in  32  instruction word, valid the cycle after imem_en
dec_valid  out  1  head entry available to decode
dec_ready  in  1  decode accepts head entry this cycle
dec_instr  out  32  head instruction
dec_pc  out  32  PC of head instruction

Behaviour:
- Reset (async, rst=1):
  - fetch_pc=RESET_PC, occupancy=0, inflight=0, FIFO pointers=0.
  - dec_valid=0, imem_en=0, dec_instr=0, dec_pc=0.
  - First request is issued in the first cycle with rst=0.
- State: fetch_pc; FIFO storage {pc, instr} x DEPTH with rd/wr pointers and occ counter (0..DEPTH); inflight bit; inflight_pc.
- Issue rule, no redirect: imem_en=1 when occ + inflight < DEPTH.
  - Pops in the same cycle do not count toward the check.
  - imem_addr=fetch_pc. On issue: inflight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^32, wraps).
  - No issue: inflight<=0, fetch_pc holds, imem_addr=fetch_pc.
- Response: when inflight=1, imem_rdata is pushed with inflight_pc at the next edge.
  - The issue rule guarantees space, so there is no overflow path.
  - A push to a full FIFO is a design error; flag it with an assertion.
- Decode side:
  - dec_valid = (occ != 0) && !redirect; dec_instr/dec_pc come from the head entry.
  - dec_instr/dec_pc = 0 when occ=0.
  - Pop when dec_valid && dec_ready.
  - Simultaneous push and pop: occ unchanged, both pointers advance.
  - While dec_valid=1 and dec_ready=0, the head entry is held stable.
- Redirect (priority over everything):
  - Same cycle: imem_en=1, imem_addr={redirect_pc[31:2],2'b00}; no pop occurs.
  - Next edge: FIFO cleared (occ=0, pointers=0); any response from the previous request is discarded.
  - Also at that edge: inflight<=1, inflight_pc<=redirect target, fetch_pc<=target+4.
- Redirect latency: redirect in cycle T → target pushed at end of T+1 → dec_valid=1 with dec_pc=target in cycle T+2.
- Sequential latency: issue in cycle T → entry visible to decode in cycle T+2.
- Throughput: steady 1 instruction/cycle while dec_ready=1.
- Back-to-back redirects: each cancels the previous; only the last target is delivered.
- Redirect while full with dec_ready=1: no pop is accepted, FIFO is cleared.
- Reset asserted mid-operation: immediate return to the reset state; no stale entry appears after release.

Test Plan:
- Reset and stream: memory word at address A = 32'hA000_0000|A, dec_ready=1, rst released → imem_addr 0,4,8,… one per cycle; dec_valid first in cycle 2 with dec_pc=0, dec_instr=32'hA000_0000; then consecutive PCs every cycle, no gaps.
- Backpressure fill: dec_ready=0 from release → imem_en stops once occ+inflight=4; dec_pc holds 0; raise dec_ready → pcs 0,4,8,12,16… in order, none lost or duplicated.
- Redirect mid-stream: redirect=1, redirect_pc=32'h0000_0103 while the fetch at 0x20 is inflight → imem_addr=0x100 that cycle; the 0x20 word is discarded; two cycles later dec_pc=0x100, then 0x104.
- Redirect while full, dec_ready=1: FIFO holds 4 entries → dec_valid=0 during the redirect cycle, no pop counted, queue empty next cycle, only the target stream follows.
- Back-to-back redirects to 0x200 then 0x300 → first delivered dec_pc=0x300; 0x200 never appears.
- Reset mid-operation with 3 entries queued: assert rst for one cycle → dec_valid=0 immediately; after release the stream restarts at RESET_PC with no stale entries.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end signal bundle: redirect input from EX, instruction-memory port A,
// and the decode valid/ready handshake.
interface fetch_queue_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;

  // master: the fetch queue itself; slave: the core/memory around it
  modport master (
    input  redirect, redirect_pc, imem_rdata, dec_ready,
    output imem_en, imem_addr, dec_valid, dec_instr, dec_pc
  );

  modport slave (
    output redirect, redirect_pc, imem_rdata, dec_ready,
    input  imem_en, imem_addr, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential fetch from a 1-cycle BRAM into a small
// {pc, instr} FIFO feeding decode, with flush-and-refetch on EX redirects.
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc;
  logic             inflight;
  logic [31:0]      inflight_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [OCC_W-1:0] occ;
  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];

  logic [31:0] redir_target;
  logic        can_issue;
  logic        not_empty;
  logic        push;
  logic        pop;
  logic        unused_rpc_bits;

  assign redir_target    = {bus.redirect_pc[31:2], 2'b00};
  assign unused_rpc_bits = ^bus.redirect_pc[1:0];

  // Space check counts the outstanding response but not a same-cycle pop.
  assign can_issue = (32'(occ) + 32'(inflight)) < DEPTH;
  assign not_empty = (occ != '0);
  assign push      = inflight && !bus.redirect;
  assign pop       = bus.dec_valid && bus.dec_ready;

  assign bus.imem_en   = !rst && (bus.redirect || can_issue);
  assign bus.imem_addr = bus.redirect ? redir_target : fetch_pc;
  assign bus.dec_valid = not_empty && !bus.redirect;
  assign bus.dec_instr = not_empty ? mem_instr[rd_ptr] : 32'h0;
  assign bus.dec_pc    = not_empty ? mem_pc[rd_ptr]    : 32'h0;

  // Control state: fetch pointer, outstanding request, FIFO pointers/occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
    end else if (bus.redirect) begin
      // Flush drops queued entries and the response returning this cycle.
      fetch_pc    <= redir_target + 32'd4;
      inflight    <= 1'b1;
      inflight_pc <= redir_target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
    end else begin
      if (can_issue) begin
        fetch_pc    <= fetch_pc + 32'd4;
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
      end else begin
        inflight    <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy gates what decode sees.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]    <= inflight_pc;
      mem_instr[wr_ptr] <= bus.imem_rdata;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && (occ == OCC_W'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: per-cycle vector table for reset/stream/backpressure,
// plus scoreboarded sequences for redirects and mid-operation reset.
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // BRAM model: word at address A reads as 32'hA000_0000 | A, one cycle later.
  always @(posedge clk) begin
    if (bus.imem_en) bus.imem_rdata <= 32'hA000_0000 | bus.imem_addr;
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_dv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        vecs [$];
  logic [31:0] exp_q [$];
  int          n_pass  = 0;
  int          n_total = 0;

  function automatic vec_t mk(input logic r, input logic rdy, input logic en,
                              input logic [31:0] addr, input logic dv, input logic [31:0] pc);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.e_en = en; v.e_addr = addr; v.e_dv = dv; v.e_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // One cycle: drive at negedge, sample 1ns later, score any accepted entry.
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    logic [31:0] e;
    @(negedge clk);
    rst = 1'b0;
    bus.dec_ready   = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    #1;
    if (rd) exp_q.delete();
    if (bus.dec_valid && bus.dec_ready) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_extra: got pc %h expected no entry", bus.dec_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", bus.dec_pc, e);
        chk("sb_instr", bus.dec_instr, 32'hA000_0000 | e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.redirect = 1'b0;
    #1;
    chk("rst_dv", 32'(bus.dec_valid), 32'd0);
    chk("rst_en", 32'(bus.imem_en), 32'd0);
    chk("rst_pc", bus.dec_pc, 32'd0);
    exp_q.delete();
  endtask

  task automatic push_stream(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.dec_ready   = 1'b0;
    bus.imem_rdata  = 32'h0;

    // Reset then free-running stream
    vecs.push_back(mk(1, 1, 0, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h04, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h08, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h0C, 1, 32'h4));
    vecs.push_back(mk(0, 1, 1, 32'h10, 1, 32'h8));
    // Reset then backpressure fill and drain
    vecs.push_back(mk(1, 0, 0, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h00, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h04, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h08, 1, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h0C, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h10, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h10, 1, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h10, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h10, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h10, 1, 32'h4));
    vecs.push_back(mk(0, 1, 1, 32'h14, 1, 32'h8));
    vecs.push_back(mk(0, 1, 1, 32'h18, 1, 32'hC));
    vecs.push_back(mk(0, 1, 1, 32'h1C, 1, 32'h10));

    foreach (vecs[i]) begin
      @(negedge clk);
      rst           = vecs[i].rst;
      bus.dec_ready = vecs[i].rdy;
      bus.redirect  = 1'b0;
      #1;
      chk($sformatf("v%0d_en", i),   32'(bus.imem_en),   32'(vecs[i].e_en));
      chk($sformatf("v%0d_addr", i), bus.imem_addr,      vecs[i].e_addr);
      chk($sformatf("v%0d_dv", i),   32'(bus.dec_valid), 32'(vecs[i].e_dv));
      chk($sformatf("v%0d_pc", i),   bus.dec_pc,         vecs[i].e_pc);
      chk($sformatf("v%0d_instr", i), bus.dec_instr,
          vecs[i].e_dv ? (32'hA000_0000 | vecs[i].e_pc) : 32'h0);
    end

    // Redirect while the 0x20 fetch is outstanding
    do_reset();
    push_stream(32'h0, 7);
    for (int c = 0; c < 9; c++) step(1'b1, 1'b0, 32'h0);
    chk("mid_drained", 32'(exp_q.size()), 32'd0);
    step(1'b1, 1'b1, 32'h0000_0103);
    chk("mid_redir_en", 32'(bus.imem_en), 32'd1);
    chk("mid_redir_addr", bus.imem_addr, 32'h100);
    chk("mid_redir_dv", 32'(bus.dec_valid), 32'd0);
    push_stream(32'h100, 3);
    step(1'b1, 1'b0, 32'h0);
    chk("mid_gap_dv", 32'(bus.dec_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("mid_first_pc", bus.dec_pc, 32'h100);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("mid_all_seen", 32'(exp_q.size()), 32'd0);

    // Redirect while full with decode ready
    do_reset();
    for (int c = 0; c < 6; c++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h400);
    chk("full_redir_dv", 32'(bus.dec_valid), 32'd0);
    chk("full_redir_addr", bus.imem_addr, 32'h400);
    push_stream(32'h400, 3);
    step(1'b1, 1'b0, 32'h0);
    chk("full_cleared_dv", 32'(bus.dec_valid), 32'd0);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 32'h0);
    chk("full_all_seen", 32'(exp_q.size()), 32'd0);

    // Back-to-back redirects: only the second target is delivered
    do_reset();
    push_stream(32'h0, 4);
    for (int c = 0; c < 6; c++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h200);
    chk("b2b_first_drained", 32'(exp_q.size()), 32'd0);
    step(1'b1, 1'b1, 32'h300);
    chk("b2b_second_addr", bus.imem_addr, 32'h300);
    push_stream(32'h300, 3);
    step(1'b1, 1'b0, 32'h0);
    chk("b2b_gap_dv", 32'(bus.dec_valid), 32'd0);
    step(1'b1, 1'b0, 32'h0);
    chk("b2b_first_pc", bus.dec_pc, 32'h300);
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("b2b_all_seen", 32'(exp_q.size()), 32'd0);

    // Reset with three entries queued
    do_reset();
    for (int c = 0; c < 5; c++) step(1'b0, 1'b0, 32'h0);
    chk("mr_pre_dv", 32'(bus.dec_valid), 32'd1);
    do_reset();
    push_stream(32'h0, 4);
    step(1'b1, 1'b0, 32'h0);
    chk("mr_restart_addr", bus.imem_addr, 32'h0);
    chk("mr_restart_dv", 32'(bus.dec_valid), 32'd0);
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 32'h0);
    chk("mr_all_seen", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
